// File: rtl/adc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_seq_pkg
// Description : Shared types, widths and the voltage-code helper for the
//               dual-ADC conversion sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_seq_pkg;

  localparam int DATA_W = 16;
  localparam int VOLT_W = 12;
  localparam int ERR_W  = 8;
  localparam int RATE_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK_WAIT = 2'd1,
    CAPTURE  = 2'd2
  } state_t;

  // Negative readings clamp to zero; positive ones keep the 12 bits below
  // the sign, dropping the three least significant noise bits.
  function automatic logic [VOLT_W-1:0] volt_code(input logic [DATA_W-1:0] data);
    return data[DATA_W-1] ? '0 : data[DATA_W-2 -: VOLT_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_rate_meter.sv
`default_nettype none
// ============================================================================
// Module      : adc_rate_meter
// Description : Counts completed conversion pairs over a fixed window of
//               clock cycles and publishes the count at each window end.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_rate_meter
  import adc_seq_pkg::*;
#(
  parameter int RATE_WINDOW = 27000000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              eoc,
  output logic [RATE_W-1:0] rate
);

  localparam int WIN_W = (RATE_WINDOW > 1) ? $clog2(RATE_WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(RATE_WINDOW - 1);

  logic [WIN_W-1:0]  win_cnt;
  logic [RATE_W-1:0] pair_cnt;
  logic [RATE_W-1:0] pair_next;

  // Pair count including this cycle's completion, held at all-ones.
  always_comb begin
    pair_next = pair_cnt;
    if (eoc && (pair_cnt != '1)) begin
      pair_next = pair_cnt + 1'b1;
    end
  end

  // Window counter; on the last cycle publish the count and restart it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_cnt  <= '0;
      pair_cnt <= '0;
      rate     <= '0;
    end else if (win_cnt == WIN_LAST) begin
      win_cnt  <= '0;
      pair_cnt <= '0;
      rate     <= pair_next;
    end else begin
      win_cnt  <= win_cnt + 1'b1;
      pair_cnt <= pair_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_pair_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : adc_pair_sequencer
// Description : Sequences a simultaneous conversion on two ADCs per start
//               pulse, captures and clamps both results, flags overruns and
//               timeouts, and measures the completed-pair rate.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_pair_sequencer
  import adc_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 270000,
  parameter int RATE_WINDOW    = 27000000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              clr_i,
  input  logic              adc1_ready_i,
  input  logic              adc2_ready_i,
  input  logic [DATA_W-1:0] adc1_data_i,
  input  logic [DATA_W-1:0] adc2_data_i,
  output logic              adc1_enable_o,
  output logic              adc2_enable_o,
  output logic [DATA_W-1:0] raw1_o,
  output logic [DATA_W-1:0] raw2_o,
  output logic [VOLT_W-1:0] vfc_o,
  output logic [VOLT_W-1:0] vout_o,
  output logic              eoc_o,
  output logic              busy_o,
  output logic              timeout_o,
  output logic              overrun_o,
  output logic [ERR_W-1:0]  err_cnt_o,
  output logic [RATE_W-1:0] rate_o
);

  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state;
  state_t          state_next;
  logic            done1;
  logic            done2;
  logic [TO_W-1:0] to_cnt;

  logic            expired;
  logic            start_conv;
  logic            cap1;
  logic            cap2;
  logic            abort;
  logic            finish;
  logic            overrun_evt;

  logic [1:0]       err_inc;
  logic [ERR_W-1:0] err_base;
  logic [ERR_W:0]   err_sum;
  logic [ERR_W-1:0] err_next;

  assign busy_o      = (state != IDLE);
  assign overrun_evt = start_i && busy_o;
  assign expired     = (to_cnt == TO_LAST);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-cycle control; timeout takes precedence over capture
  // so an aborted conversion leaves the published results untouched.
  always_comb begin
    state_next = state;
    start_conv = 1'b0;
    cap1       = 1'b0;
    cap2       = 1'b0;
    abort      = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          start_conv = 1'b1;
          state_next = ACK_WAIT;
        end
      end
      ACK_WAIT: begin
        if (expired) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (!adc1_ready_i && !adc2_ready_i) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (expired) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else begin
          cap1 = adc1_ready_i && !done1;
          cap2 = adc2_ready_i && !done2;
          if ((done1 || cap1) && (done2 || cap2)) begin
            finish     = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Enables, done flags, timeout counter and captured results.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      adc1_enable_o <= 1'b0;
      adc2_enable_o <= 1'b0;
      done1         <= 1'b0;
      done2         <= 1'b0;
      to_cnt        <= '0;
      raw1_o        <= '0;
      raw2_o        <= '0;
      vfc_o         <= '0;
      vout_o        <= '0;
    end else if (start_conv) begin
      adc1_enable_o <= 1'b1;
      adc2_enable_o <= 1'b1;
      done1         <= 1'b0;
      done2         <= 1'b0;
      to_cnt        <= '0;
    end else if (busy_o) begin
      to_cnt <= to_cnt + 1'b1;
      if (abort) begin
        adc1_enable_o <= 1'b0;
        adc2_enable_o <= 1'b0;
      end
      if (cap1) begin
        raw1_o        <= adc1_data_i;
        vfc_o         <= volt_code(adc1_data_i);
        adc1_enable_o <= 1'b0;
        done1         <= 1'b1;
      end
      if (cap2) begin
        raw2_o        <= adc2_data_i;
        vout_o        <= volt_code(adc2_data_i);
        adc2_enable_o <= 1'b0;
        done2         <= 1'b1;
      end
    end
  end

  // Error accounting: a clear and an event on the same edge leave only the
  // new events counted.
  always_comb begin
    err_inc  = {1'b0, overrun_evt} + {1'b0, abort};
    err_base = clr_i ? '0 : err_cnt_o;
    err_sum  = {1'b0, err_base} + {{(ERR_W - 1){1'b0}}, err_inc};
    err_next = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
  end

  // Status pulses and sticky error state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      eoc_o     <= 1'b0;
      timeout_o <= 1'b0;
      overrun_o <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      eoc_o     <= finish;
      timeout_o <= abort;
      err_cnt_o <= err_next;
      if (overrun_evt) begin
        overrun_o <= 1'b1;
      end else if (clr_i) begin
        overrun_o <= 1'b0;
      end
    end
  end

  adc_rate_meter #(
    .RATE_WINDOW(RATE_WINDOW)
  ) u_rate_meter (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .eoc   (eoc_o),
    .rate  (rate_o)
  );

endmodule
`default_nettype wire
